// File: rtl/rom_arbiter.sv
// rom_arbiter: two-port round-robin arbiter in front of a combinational ROM.
//
// Port 0 is the instruction fetch side and port 1 is the data load side.
// A request sampled in IDLE is granted in the following cycle (gnt pulse,
// ROM address presented from a register). The read data is returned one
// cycle after that (rvalid pulse). This gives one access per two cycles at
// peak. When both ports request together, the port that was not granted
// last wins.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   req0_i, addr0_i            port 0 request level and read address
//   gnt0_o, rvalid0_o          port 0 accept pulse and data-valid pulse
//   rdata0_o                   port 0 read data (held between accesses)
//   req1_i ... rdata1_o        the same signals for port 1
//   rom_addr_o                 registered ROM address
//   rom_data_i                 combinational ROM data for rom_addr_o
//   dbg_state_o                FSM state (0 = IDLE, 1 = READ)
//
// Handshake: reqN_i is a level held high, with addrN_i stable, until gnt0_o
// or gnt1_o pulses for that port. In the cycle after gnt the requester
// either drops reqN_i or presents its next address. Because that cycle is
// always IDLE, a req still high there is a fresh request. rvalidN_o pulses
// exactly one cycle after gntN_o. Request changes during READ are ignored.
module rom_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req0_i,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  output logic                  gnt0_o,
  output logic                  rvalid0_o,
  output logic [DATA_WIDTH-1:0] rdata0_o,
  input  logic                  req1_i,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  output logic                  gnt1_o,
  output logic                  rvalid1_o,
  output logic [DATA_WIDTH-1:0] rdata1_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic                  dbg_state_o
);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic                    last_q, last_d;
  logic                    owner_q, owner_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    gnt0_q, gnt0_d;
  logic                    gnt1_q, gnt1_d;
  logic                    rvalid0_q, rvalid0_d;
  logic                    rvalid1_q, rvalid1_d;
  logic [DATA_WIDTH-1:0]   rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0]   rdata1_q, rdata1_d;
  logic                    winner;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      // last_q starts at 1 so that port 0 wins the first tie.
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      addr_q    <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    winner    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0_i || req1_i) begin
          // On a tie, the port that did not win last time takes this slot.
          // Otherwise the only requester wins.
          if (req0_i && req1_i) winner = ~last_q;
          else                  winner = req1_i;
          addr_d  = winner ? addr1_i : addr0_i;
          owner_d = winner;
          last_d  = winner;
          gnt0_d  = ~winner;
          gnt1_d  = winner;
          state_d = READ;
        end
      end
      READ: begin
        // rom_addr_o has been stable from addr_q for the whole cycle, so
        // rom_data_i is valid to capture for the owner.
        if (owner_q) begin
          rdata1_d  = rom_data_i;
          rvalid1_d = 1'b1;
        end else begin
          rdata0_d  = rom_data_i;
          rvalid0_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt0_o      = gnt0_q;
  assign gnt1_o      = gnt1_q;
  assign rvalid0_o   = rvalid0_q;
  assign rvalid1_o   = rvalid1_q;
  assign rdata0_o    = rdata0_q;
  assign rdata1_o    = rdata1_q;
  assign rom_addr_o  = addr_q;
  assign dbg_state_o = (state_q == READ);

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: randomized and directed bench for rom_arbiter.
// The reference model is a cycle schedule. Each accepted request books a
// grant one cycle later and a data return two cycles later. The arbiter is
// then free again from the return cycle onward.
module tb_rom_arbiter;

  localparam int          AW      = 32;
  localparam int          DW      = 32;
  localparam int          MAXC    = 4096;
  localparam logic [31:0] ROM_KEY = 32'hA5A5A5A5;

  // clock / reset block
  logic          clk_i = 1'b0;
  logic          rst_ni;
  always #5 clk_i = ~clk_i;

  logic          req0_i, req1_i;
  logic [AW-1:0] addr0_i, addr1_i;
  logic          gnt0_o, gnt1_o, rvalid0_o, rvalid1_o;
  logic [DW-1:0] rdata0_o, rdata1_o;
  logic [AW-1:0] rom_addr_o;
  logic [DW-1:0] rom_data_i;
  logic          dbg_state_o;

  // Combinational ROM contents: data = address ^ key.
  assign rom_data_i = rom_addr_o ^ ROM_KEY;

  rom_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req0_i     (req0_i),
    .addr0_i    (addr0_i),
    .gnt0_o     (gnt0_o),
    .rvalid0_o  (rvalid0_o),
    .rdata0_o   (rdata0_o),
    .req1_i     (req1_i),
    .addr1_i    (addr1_i),
    .gnt1_o     (gnt1_o),
    .rvalid1_o  (rvalid1_o),
    .rdata1_o   (rdata1_o),
    .rom_addr_o (rom_addr_o),
    .rom_data_i (rom_data_i),
    .dbg_state_o(dbg_state_o)
  );

  // scoreboard state
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          ev_gnt [MAXC];   // port granted in cycle, -1 if none
  int          ev_rv  [MAXC];   // port receiving data in cycle, -1 if none
  logic [31:0] ev_addr[MAXC];
  logic [31:0] ev_data[MAXC];
  int          m_last;          // port granted most recently
  int          m_free;          // first cycle whose end may accept
  logic [31:0] m_rom_addr;
  logic [31:0] m_rdata[2];
  logic [31:0] exp_q0[$];       // addresses port 0 will still request
  logic [31:0] exp_q1[$];
  logic        pend[2];
  logic [31:0] cur_addr[2];
  int          obs_gnt[2];
  int          obs_rv[2];
  bit          rand_mode = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < MAXC; i++) begin
      ev_gnt[i] = -1;
      ev_rv[i]  = -1;
    end
    m_last     = 1;
    m_free     = 1 << 30;
    m_rom_addr = '0;
    m_rdata[0] = '0;
    m_rdata[1] = '0;
    pend[0]    = 1'b0;
    pend[1]    = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    req0_i     = 1'b0;
    req1_i     = 1'b0;
    addr0_i    = '0;
    addr1_i    = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_gnt0"},   gnt0_o,      0);
    check_val({tag, "_gnt1"},   gnt1_o,      0);
    check_val({tag, "_rv0"},    rvalid0_o,   0);
    check_val({tag, "_rv1"},    rvalid1_o,   0);
    check_val({tag, "_rdata0"}, rdata0_o,    0);
    check_val({tag, "_rdata1"}, rdata1_o,    0);
    check_val({tag, "_romaddr"}, rom_addr_o, 0);
    check_val({tag, "_state"},  dbg_state_o, 0);
  endtask

  // One clock cycle: check outputs mid-cycle, update requesters, then book
  // what the arbiter must do at the coming rising edge.
  task automatic step(input bit release_rst = 1'b0);
    int c;
    int w;
    @(negedge clk_i);
    c = cyc;
    if (ev_gnt[c] != -1) m_rom_addr = ev_addr[c];
    if (ev_rv[c]  != -1) m_rdata[ev_rv[c]] = ev_data[c];
    check_val("gnt0",    gnt0_o,      ev_gnt[c] == 0);
    check_val("gnt1",    gnt1_o,      ev_gnt[c] == 1);
    check_val("rvalid0", rvalid0_o,   ev_rv[c] == 0);
    check_val("rvalid1", rvalid1_o,   ev_rv[c] == 1);
    check_val("rdata0",  rdata0_o,    m_rdata[0]);
    check_val("rdata1",  rdata1_o,    m_rdata[1]);
    check_val("romaddr", rom_addr_o,  m_rom_addr);
    check_val("state",   dbg_state_o, ev_gnt[c] != -1);
    if (gnt0_o)    obs_gnt[0]++;
    if (gnt1_o)    obs_gnt[1]++;
    if (rvalid0_o) obs_rv[0]++;
    if (rvalid1_o) obs_rv[1]++;

    if (release_rst) begin
      rst_ni = 1'b1;
      m_free = c;
    end

    // driver: requesters follow the model's grant schedule
    if (pend[0] && ev_gnt[c] == 0) pend[0] = 1'b0;
    if (pend[1] && ev_gnt[c] == 1) pend[1] = 1'b0;
    if (rand_mode && exp_q0.size() == 0 && $urandom_range(0, 3) == 0) exp_q0.push_back($urandom());
    if (rand_mode && exp_q1.size() == 0 && $urandom_range(0, 3) == 0) exp_q1.push_back($urandom());
    if (!pend[0] && exp_q0.size() > 0 && (!rand_mode || $urandom_range(0, 2) != 0)) begin
      pend[0] = 1'b1;
      cur_addr[0] = exp_q0.pop_front();
    end
    if (!pend[1] && exp_q1.size() > 0 && (!rand_mode || $urandom_range(0, 2) != 0)) begin
      pend[1] = 1'b1;
      cur_addr[1] = exp_q1.pop_front();
    end
    req0_i  = pend[0];
    req1_i  = pend[1];
    addr0_i = pend[0] ? cur_addr[0] : $urandom();
    addr1_i = pend[1] ? cur_addr[1] : $urandom();

    // reference arbitration for the edge that ends cycle c
    if (c >= m_free && (pend[0] || pend[1])) begin
      if (pend[0] && pend[1]) w = 1 - m_last;
      else                    w = pend[1] ? 1 : 0;
      m_last         = w;
      ev_gnt[c + 1]  = w;
      ev_addr[c + 1] = cur_addr[w];
      ev_rv[c + 2]   = w;
      ev_data[c + 2] = cur_addr[w] ^ ROM_KEY;
      m_free         = c + 2;
    end
    cyc++;
  endtask

  task automatic apply_reset(input int hold);
    #2;
    rst_ni = 1'b0;
    #1;
    check_all_zero("rst_async");
    model_clear();
    repeat (hold) step();
    step(1'b1);
  endtask

  initial begin
    rst_ni = 1'b1;
    model_clear();
    #1;
    rst_ni = 1'b0;
    #1;
    check_all_zero("rst_init");
    repeat (2) step();
    step(1'b1);

    // single port 0 access
    exp_q0.push_back(32'h10);
    repeat (2) step();
    check_val("t1_gnt0", gnt0_o, 1);
    check_val("t1_romaddr", rom_addr_o, 32'h10);
    step();
    check_val("t1_rvalid0", rvalid0_o, 1);
    check_val("t1_rdata0", rdata0_o, 32'hA5A5A5B5);

    // simultaneous first requests after reset: port 0 wins the tie
    apply_reset(1);
    exp_q0.push_back(32'h4);
    exp_q1.push_back(32'h8);
    repeat (2) step();
    check_val("t2_gnt0", gnt0_o, 1);
    repeat (2) step();
    check_val("t2_gnt1", gnt1_o, 1);
    step();
    check_val("t2_rvalid1", rvalid1_o, 1);
    check_val("t2_rdata1", rdata1_o, 32'h8 ^ ROM_KEY);
    check_val("t2_rdata0_held", rdata0_o, 32'h4 ^ ROM_KEY);

    // both ports continuously requesting: strict alternation
    apply_reset(0);
    for (int i = 0; i < 12; i++) begin
      exp_q0.push_back(32'h1000 + i * 4);
      exp_q1.push_back(32'h2000 + i * 4);
    end
    obs_gnt[0] = 0;
    obs_gnt[1] = 0;
    repeat (20) step();
    check_val("t3_gnt0_count", obs_gnt[0], 5);
    check_val("t3_gnt1_count", obs_gnt[1], 5);

    // reset in the READ cycle after gnt1 aborts the access
    apply_reset(0);
    exp_q1.push_back(32'h200);
    repeat (2) step();
    check_val("t4_gnt1", gnt1_o, 1);
    apply_reset(1);
    obs_rv[1] = 0;
    repeat (3) step();
    check_val("t4_no_rvalid1", obs_rv[1], 0);
    exp_q1.push_back(32'h300);
    repeat (2) step();
    check_val("t4_regnt1", gnt1_o, 1);
    step();
    check_val("t4_rvalid1", rvalid1_o, 1);
    check_val("t4_rdata1", rdata1_o, 32'h300 ^ ROM_KEY);

    // port 1 alone, back to back
    apply_reset(0);
    exp_q1.push_back(32'h100);
    exp_q1.push_back(32'h104);
    obs_gnt[0] = 0;
    obs_gnt[1] = 0;
    obs_rv[0]  = 0;
    obs_rv[1]  = 0;
    repeat (6) step();
    check_val("t5_gnt1_count", obs_gnt[1], 2);
    check_val("t5_rv1_count", obs_rv[1], 2);
    check_val("t5_gnt0_count", obs_gnt[0], 0);
    check_val("t5_rv0_count", obs_rv[0], 0);
    check_val("t5_rdata1", rdata1_o, 32'h104 ^ ROM_KEY);

    // randomized traffic with occasional resets
    rand_mode = 1'b1;
    repeat (1500) begin
      step();
      if ($urandom_range(0, 499) == 0) apply_reset($urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: width of all address ports.
REQ-002 Parameter DATA_WIDTH, default 32: width of all data ports.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 req0_i  input  1  port 0 (instruction fetch) read request; level, held until gnt0_o.
REQ-006 addr0_i  input  ADDR_WIDTH  port 0 read address; stable while req0_i high and gnt0_o low.
REQ-007 gnt0_o  output  1  port 0 request accepted; one-cycle pulse.
REQ-008 rvalid0_o  output  1  port 0 read data valid; one-cycle pulse.
REQ-009 rdata0_o  output  DATA_WIDTH  port 0 read data.
REQ-010 req1_i, addr1_i, gnt1_o, rvalid1_o, rdata1_o  same as REQ-005..009 for port 1 (data load).
REQ-011 rom_addr_o  output  ADDR_WIDTH  address to the combinational ROM, driven from a register.
REQ-012 rom_data_i  input  DATA_WIDTH  combinational ROM read data for rom_addr_o.

Function
REQ-013 FSM states: IDLE, READ; the block accepts a new request only in IDLE.
REQ-014 IDLE, no req: stay IDLE; no gnt, no rvalid; rom_addr_o holds its previous value.
REQ-015 IDLE, exactly one req high at edge: that port wins.
REQ-016 IDLE, both req high: round-robin; winner is the port not granted last (last_q); last_q resets to 1, so port 0 wins the first tie.
REQ-017 On accept edge (end of cycle T): addr_q <= winner addr, owner_q <= winner, last_q <= winner, winner gnt register <= 1, state <= READ.
REQ-018 Cycle T+1 (READ): rom_addr_o = addr_q; gnt of owner high for exactly this cycle; other gnt low.
REQ-019 End of READ: owner rdata register <= rom_data_i, owner rvalid <= 1, state <= IDLE.
REQ-020 Cycle T+2: owner rvalid high for exactly one cycle; new requests sampled in same cycle; next gnt earliest T+3.
REQ-021 Fixed latency: req sampled alone in IDLE -> gnt 1 cycle later -> rvalid 2 cycles later; peak throughput one access per 2 cycles.
REQ-022 Requester deasserts req or presents its next address in the cycle after gnt; req still high in IDLE counts as a new request.
REQ-023 rdataN_o holds its last captured value until the next rvalidN_o; never changes on the other port's access.
REQ-024 gnt0_o & gnt1_o never both 1; rvalid0_o & rvalid1_o never both 1.
REQ-025 Continuous requests from both ports strictly alternate grants; no port starves beyond one access of the other.
REQ-026 Request changes during READ ignored; the losing port's req stays pending and wins at the next IDLE sample under REQ-016.
REQ-027 Address passes unmodified, full ADDR_WIDTH; no bounds check or wrap.

Reset
REQ-028 rst_ni low immediately forces state IDLE, last_q = 1, owner_q = 0, addr_q = 0, rom_addr_o = 0, all gnt/rvalid = 0, rdata0_o = rdata1_o = 0.
REQ-029 Reset during READ aborts the access: no rvalid is produced for it; after release, the requester must re-request.
REQ-030 First accept edge is the first rising clk_i edge with rst_ni high.

Verification
REQ-031 Single port 0: req0=1, addr0=0x10 in cycle 1, ROM model data=addr^0xA5A5A5A5 -> gnt0 cycle 2, rom_addr_o=0x10 cycle 2, rvalid0 cycle 3 with rdata0=0xA5A5A5B5.
REQ-032 Simultaneous first requests: req0 addr 0x4, req1 addr 0x8 in cycle 1 -> gnt0 cycle 2, rvalid0 cycle 3; gnt1 cycle 4, rvalid1 cycle 5; rdata0 unchanged in cycle 5.
REQ-033 Both ports held high with new address after each gnt for 20 cycles -> grants alternate 0,1,0,1, one every 2 cycles, 10 total, 5 per port.
REQ-034 Reset asserted during READ after gnt1 -> outputs zero asynchronously, no rvalid1; after release, req1 reissued -> normal gnt/rvalid timing.
REQ-035 Port 1 alone back-to-back (addr 0x100 then 0x104) -> gnt1 cycles 2 and 4, rvalid1 cycles 3 and 5, correct data each, gnt0/rvalid0 never high.
